ttt_board_ctrl: RTL and testbench
=================================

// Module: ttt_board_ctrl
// PURPOSE
//  Game-state engine upstream of the tic-tac-toe VGA renderer. Takes the cursor square and a debounced
//  rotary-press strobe, places the current player's mark, alternates turns, and detects win/draw through a small FSM.
//  Drives per-square status codes, turn, and result flags consumed by the display stage.
// PARAMETERS
//  FIRST_PLAYER     1'b0  player who moves first after reset (0 = player 1, 1 = player 2)
//  ALTERNATE_START  1     1: each new_game starts with the opposite of the previous game's first player; 0: always FIRST_PLAYER
// PORTS
//  clk             in   1   system clock; single clock domain
//  clr_n           in   1   reset, asynchronous, active-low
//  square_num      in   8   cursor square; 1..9 valid (row-major, 1 = top-left); 0 and 10..255 invalid
//  enter           in   1   debounced rotary-press level; block edge-detects internally
//  new_game        in   1   synchronous restart request, level-sampled each cycle
//  board_status    out  18  square k status at [2k-1:2k-2]: 00 empty, 01 player 1, 10 player 2; 11 never driven
//  player_turn     out  1   player to move (0 = player 1, 1 = player 2)
//  move_accepted   out  1   one-cycle pulse: mark written
//  move_rejected   out  1   one-cycle pulse: press ignored (invalid/occupied square)
//  player_1_win    out  1   high while game ended with a player 1 line
//  player_2_win    out  1   high while game ended with a player 2 line
//  draw            out  1   high while board full with no line
//  win_line        out  8   one-hot winning line; 0 unless a win flag is high
//  move_count      out  4   marks placed this game, 0..9
// BEHAVIOUR
//  Reset (clr_n low, async): board_status=0, player_turn=FIRST_PLAYER, all pulses/flags/win_line=0,
//   move_count=0, FSM=PLAY, internal enter_d=1 (an enter held high across reset yields no move until released and re-pressed).
//  press = enter & ~enter_d, evaluated every cycle; enter_d <= enter.
//  FSM states: PLAY, CHECK, WIN, DRAW.
//  PLAY: on press at cycle N:
//   - square_num in 1..9 and that square is 00: at N+1 write {player_turn==1,player_turn==0} to it,
//     move_count+1, move_accepted=1 for that one cycle, FSM->CHECK.
//   - otherwise: move_rejected=1 at N+1 for one cycle; board, turn, and move_count unchanged; stay in PLAY.
//  CHECK (exactly one cycle, N+1->N+2): evaluate 8 lines on the updated board.
//   win_line bits: 0 row 1-2-3, 1 row 4-5-6, 2 row 7-8-9, 3 col 1-4-7, 4 col 2-5-8, 5 col 3-6-9, 6 diag 1-5-9, 7 diag 3-5-7.
//   - line owned by mover: at N+2 set player_1_win or player_2_win, win_line (several bits possible), FSM->WIN; turn not toggled.
//   - else move_count==9: draw=1, FSM->DRAW.
//   - else: player_turn toggles, FSM->PLAY.
//   - Win beats draw when the 9th mark completes a line.
//   - Presses arriving while in CHECK are dropped silently (no pulse).
//  WIN/DRAW: board and flags hold; presses ignored with no pulses; leave only via new_game or reset.
//  new_game high in any state: next cycle clears board, move_count, flags, win_line, and pulses; FSM->PLAY.
//   player_turn = ~(previous game's first player) if ALTERNATE_START, else FIRST_PLAYER.
//   Takes priority over a simultaneous press; that press is discarded.
//   Held high: board stays cleared each cycle and presses are discarded.
//  All outputs registered. Press-to-move_accepted latency is 1 cycle; press-to-result/turn-toggle latency is 2 cycles.
//  No combinational path from inputs to outputs.
// TESTING
//  1. Reset, then press with square_num=5 -> N+1: board_status[9:8]=01, move_accepted=1, move_count=1; N+2: player_turn=1.
//  2. Second press on square 5 -> move_rejected=1 for one cycle, board unchanged, player_turn stays 1.
//     Press with square_num=0, and again with 12 -> move_rejected each time.
//  3. P1 plays 1,2,3 interleaved with P2 on 4,5 -> after the 3rd P1 mark + 2 cycles: player_1_win=1, win_line=8'h01;
//     a further press gives no pulse and no board change.
//  4. Sequence 1,2,3,5,4,6,8,7,9 -> draw=1, move_count=9, win flags=0.
//     Separate run where the 9th move completes diag 1-5-9 -> win flag set, draw=0, win_line=8'h40.
//  5. new_game and press in the same cycle during WIN -> board=0, FSM PLAY, no move_accepted;
//     with ALTERNATE_START=1 and FIRST_PLAYER=0, player_turn=1.
//  6. Hold enter high, pulse clr_n low mid-CHECK -> all outputs cleared immediately; no move until enter falls and rises again.

Source files
------------

// File: rtl/ttt_board_ctrl.sv
// Tic-tac-toe game-state engine: places marks from cursor presses, alternates turns,
// and resolves win/draw one cycle after each accepted move.
module ttt_board_ctrl #(
    parameter logic FIRST_PLAYER    = 1'b0,
    parameter int   ALTERNATE_START = 1
) (
    input  logic        clk,
    input  logic        clr_n,
    input  logic [7:0]  square_num,
    input  logic        enter,
    input  logic        new_game,
    output logic [17:0] board_status,
    output logic        player_turn,
    output logic        move_accepted,
    output logic        move_rejected,
    output logic        player_1_win,
    output logic        player_2_win,
    output logic        draw,
    output logic [7:0]  win_line,
    output logic [3:0]  move_count
);

    localparam logic [1:0] ST_PLAY  = 2'd0;
    localparam logic [1:0] ST_CHECK = 2'd1;
    localparam logic [1:0] ST_WIN   = 2'd2;
    localparam logic [1:0] ST_DRAW  = 2'd3;

    logic [1:0]  state_q,    state_d;
    logic [17:0] board_q,    board_d;
    logic        turn_q,     turn_d;
    logic        first_q,    first_d;
    logic        acc_q,      acc_d;
    logic        rej_q,      rej_d;
    logic        p1_win_q,   p1_win_d;
    logic        p2_win_q,   p2_win_d;
    logic        draw_q,     draw_d;
    logic [7:0]  win_line_q, win_line_d;
    logic [3:0]  count_q,    count_d;
    logic        enter_q;

    logic        press;
    logic [1:0]  mover_mark;
    logic [8:0]  sq_sel;
    logic [8:0]  occupied;
    logic [8:0]  owned;
    logic [17:0] write_vec;
    logic [7:0]  line_hit;
    logic        next_first;

    assign press      = enter & ~enter_q;
    assign mover_mark = turn_q ? 2'b10 : 2'b01;
    assign next_first = (ALTERNATE_START != 0) ? ~first_q : FIRST_PLAYER;

    // Per-square decode: cursor match, occupancy, ownership by the player to move.
    for (genvar gi = 0; gi < 9; gi++) begin : g_square
        assign sq_sel[gi]          = (square_num == 8'(gi + 1));
        assign occupied[gi]        = |board_q[2*gi +: 2];
        assign owned[gi]           = (board_q[2*gi +: 2] == mover_mark);
        assign write_vec[2*gi +: 2] = sq_sel[gi] ? mover_mark : 2'b00;
    end

    assign line_hit[0] = owned[0] & owned[1] & owned[2];
    assign line_hit[1] = owned[3] & owned[4] & owned[5];
    assign line_hit[2] = owned[6] & owned[7] & owned[8];
    assign line_hit[3] = owned[0] & owned[3] & owned[6];
    assign line_hit[4] = owned[1] & owned[4] & owned[7];
    assign line_hit[5] = owned[2] & owned[5] & owned[8];
    assign line_hit[6] = owned[0] & owned[4] & owned[8];
    assign line_hit[7] = owned[2] & owned[4] & owned[6];

    always_comb begin
        state_d    = state_q;
        board_d    = board_q;
        turn_d     = turn_q;
        first_d    = first_q;
        acc_d      = 1'b0;
        rej_d      = 1'b0;
        p1_win_d   = p1_win_q;
        p2_win_d   = p2_win_q;
        draw_d     = draw_q;
        win_line_d = win_line_q;
        count_d    = count_q;

        if (new_game) begin
            // Restart wins over any same-cycle press, which is simply dropped.
            state_d    = ST_PLAY;
            board_d    = '0;
            count_d    = '0;
            p1_win_d   = 1'b0;
            p2_win_d   = 1'b0;
            draw_d     = 1'b0;
            win_line_d = '0;
            turn_d     = next_first;
            first_d    = next_first;
        end else begin
            case (state_q)
                ST_PLAY: begin
                    if (press) begin
                        if (|(sq_sel & ~occupied)) begin
                            board_d = board_q | write_vec;
                            count_d = count_q + 4'd1;
                            acc_d   = 1'b1;
                            state_d = ST_CHECK;
                        end else begin
                            rej_d = 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (|line_hit) begin
                        p1_win_d   = ~turn_q;
                        p2_win_d   = turn_q;
                        win_line_d = line_hit;
                        state_d    = ST_WIN;
                    end else if (count_q == 4'd9) begin
                        draw_d  = 1'b1;
                        state_d = ST_DRAW;
                    end else begin
                        turn_d  = ~turn_q;
                        state_d = ST_PLAY;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // enter_q resets high so a press held across reset needs a release first.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q    <= ST_PLAY;
            board_q    <= '0;
            turn_q     <= FIRST_PLAYER;
            first_q    <= FIRST_PLAYER;
            acc_q      <= 1'b0;
            rej_q      <= 1'b0;
            p1_win_q   <= 1'b0;
            p2_win_q   <= 1'b0;
            draw_q     <= 1'b0;
            win_line_q <= '0;
            count_q    <= '0;
            enter_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            board_q    <= board_d;
            turn_q     <= turn_d;
            first_q    <= first_d;
            acc_q      <= acc_d;
            rej_q      <= rej_d;
            p1_win_q   <= p1_win_d;
            p2_win_q   <= p2_win_d;
            draw_q     <= draw_d;
            win_line_q <= win_line_d;
            count_q    <= count_d;
            enter_q    <= enter;
        end
    end

    assign board_status  = board_q;
    assign player_turn   = turn_q;
    assign move_accepted = acc_q;
    assign move_rejected = rej_q;
    assign player_1_win  = p1_win_q;
    assign player_2_win  = p2_win_q;
    assign draw          = draw_q;
    assign win_line      = win_line_q;
    assign move_count    = count_q;

endmodule

// File: tb/tb_ttt_board_ctrl.sv
// Directed table-driven bench for ttt_board_ctrl: one press per vector, checked at N+1 and N+2.
module tb_ttt_board_ctrl;

    logic        clk;
    logic        clr_n;
    logic [7:0]  square_num;
    logic        enter;
    logic        new_game;
    logic [17:0] board_status;
    logic        player_turn;
    logic        move_accepted;
    logic        move_rejected;
    logic        player_1_win;
    logic        player_2_win;
    logic        draw;
    logic [7:0]  win_line;
    logic [3:0]  move_count;

    int n_chk  = 0;
    int n_fail = 0;

    ttt_board_ctrl #(.FIRST_PLAYER(1'b0), .ALTERNATE_START(1)) dut (
        .clk(clk), .clr_n(clr_n), .square_num(square_num), .enter(enter), .new_game(new_game),
        .board_status(board_status), .player_turn(player_turn), .move_accepted(move_accepted),
        .move_rejected(move_rejected), .player_1_win(player_1_win), .player_2_win(player_2_win),
        .draw(draw), .win_line(win_line), .move_count(move_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         sq;
        bit         ng;
        bit         pre_rst;
        bit         acc;
        bit         rej;
        logic [8:0] p1m;
        logic [8:0] p2m;
        int         cnt;
        bit         turn;
        bit         p1;
        bit         p2;
        bit         dr;
        logic [7:0] wl;
    } vec_t;

    vec_t vecs[$];

    // Square k (1..9) occupies mask bit k-1.
    function automatic logic [17:0] brd(input logic [8:0] p1m, input logic [8:0] p2m);
        logic [17:0] b;
        b = '0;
        for (int k = 0; k < 9; k++) begin
            if (p1m[k])      b[2*k +: 2] = 2'b01;
            else if (p2m[k]) b[2*k +: 2] = 2'b10;
        end
        return b;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr_n = 1'b0; enter = 1'b0; new_game = 1'b0; square_num = 8'd0;
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic apply(input vec_t v, input int idx);
        if (v.pre_rst) do_reset();
        square_num = 8'(v.sq);
        enter      = 1'b1;
        new_game   = v.ng;
        @(negedge clk);
        chk("accepted_n1", 32'(move_accepted), 32'(v.acc));
        chk("rejected_n1", 32'(move_rejected), 32'(v.rej));
        chk("board_n1", 32'(board_status), 32'(brd(v.p1m, v.p2m)));
        chk("count_n1", 32'(move_count), 32'(v.cnt));
        enter    = 1'b0;
        new_game = 1'b0;
        @(negedge clk);
        chk("accepted_n2", 32'(move_accepted), 32'd0);
        chk("rejected_n2", 32'(move_rejected), 32'd0);
        chk("board_n2", 32'(board_status), 32'(brd(v.p1m, v.p2m)));
        chk("turn_n2", 32'(player_turn), 32'(v.turn));
        chk("p1win_n2", 32'(player_1_win), 32'(v.p1));
        chk("p2win_n2", 32'(player_2_win), 32'(v.p2));
        chk("draw_n2", 32'(draw), 32'(v.dr));
        chk("winline_n2", 32'(win_line), 32'(v.wl));
        $display("vec %0d: sq=%0d ng=%0d board=%05h turn=%0d cnt=%0d p1=%0d p2=%0d draw=%0d wl=%02h",
                 idx, v.sq, v.ng, board_status, player_turn, move_count,
                 player_1_win, player_2_win, draw, win_line);
    endtask

    initial begin
        clr_n = 1'b0; enter = 1'b0; new_game = 1'b0; square_num = 8'd0;

        //               sq ng rs ac rj  p1 mask       p2 mask      cnt tn p1 p2 dr wl
        // Game A: single move then rejections (occupied, 0, 12)
        vecs.push_back('{5, 0, 1, 1, 0, 9'b000010000, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{5, 0, 0, 0, 1, 9'b000010000, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{0, 0, 0, 0, 1, 9'b000010000, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{12,0, 0, 0, 1, 9'b000010000, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        // Game B: P1 wins top row, then press in WIN, then new_game with press
        vecs.push_back('{1, 0, 1, 1, 0, 9'b000000001, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{4, 0, 0, 1, 0, 9'b000000001, 9'b000001000, 2, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{2, 0, 0, 1, 0, 9'b000000011, 9'b000001000, 3, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{5, 0, 0, 1, 0, 9'b000000011, 9'b000011000, 4, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{3, 0, 0, 1, 0, 9'b000000111, 9'b000011000, 5, 0, 1, 0, 0, 8'h01});
        vecs.push_back('{9, 0, 0, 0, 0, 9'b000000111, 9'b000011000, 5, 0, 1, 0, 0, 8'h01});
        vecs.push_back('{7, 1, 0, 0, 0, 9'b000000000, 9'b000000000, 0, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{7, 0, 0, 1, 0, 9'b000000000, 9'b001000000, 1, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{0, 1, 0, 0, 0, 9'b000000000, 9'b000000000, 0, 0, 0, 0, 0, 8'h00});
        // Game C: draw 1,2,3,5,4,6,8,7,9 then a press in DRAW
        vecs.push_back('{1, 0, 0, 1, 0, 9'b000000001, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{2, 0, 0, 1, 0, 9'b000000001, 9'b000000010, 2, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{3, 0, 0, 1, 0, 9'b000000101, 9'b000000010, 3, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{5, 0, 0, 1, 0, 9'b000000101, 9'b000010010, 4, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{4, 0, 0, 1, 0, 9'b000001101, 9'b000010010, 5, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{6, 0, 0, 1, 0, 9'b000001101, 9'b000110010, 6, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{8, 0, 0, 1, 0, 9'b010001101, 9'b000110010, 7, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{7, 0, 0, 1, 0, 9'b010001101, 9'b001110010, 8, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{9, 0, 0, 1, 0, 9'b110001101, 9'b001110010, 9, 0, 0, 0, 1, 8'h00});
        vecs.push_back('{5, 0, 0, 0, 0, 9'b110001101, 9'b001110010, 9, 0, 0, 0, 1, 8'h00});
        // Game D: ninth move completes diagonal 1-5-9 (win beats draw)
        vecs.push_back('{1, 0, 1, 1, 0, 9'b000000001, 9'b000000000, 1, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{3, 0, 0, 1, 0, 9'b000000001, 9'b000000100, 2, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{2, 0, 0, 1, 0, 9'b000000011, 9'b000000100, 3, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{4, 0, 0, 1, 0, 9'b000000011, 9'b000001100, 4, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{5, 0, 0, 1, 0, 9'b000010011, 9'b000001100, 5, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{7, 0, 0, 1, 0, 9'b000010011, 9'b001001100, 6, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{6, 0, 0, 1, 0, 9'b000110011, 9'b001001100, 7, 1, 0, 0, 0, 8'h00});
        vecs.push_back('{8, 0, 0, 1, 0, 9'b000110011, 9'b011001100, 8, 0, 0, 0, 0, 8'h00});
        vecs.push_back('{9, 0, 0, 1, 0, 9'b100110011, 9'b011001100, 9, 0, 1, 0, 0, 8'h40});

        do_reset();
        chk("reset_board", 32'(board_status), 32'd0);
        chk("reset_turn", 32'(player_turn), 32'd0);
        chk("reset_count", 32'(move_count), 32'd0);
        chk("reset_pulses", 32'({move_accepted, move_rejected}), 32'd0);
        chk("reset_flags", 32'({player_1_win, player_2_win, draw, win_line}), 32'd0);
        $display("reset: board=%05h turn=%0d cnt=%0d", board_status, player_turn, move_count);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Reset mid-CHECK with enter held high
        do_reset();
        square_num = 8'd5;
        enter      = 1'b1;
        @(negedge clk);
        chk("pre_rst_accepted", 32'(move_accepted), 32'd1);
        #2 clr_n = 1'b0;
        #1;
        chk("async_board", 32'(board_status), 32'd0);
        chk("async_count", 32'(move_count), 32'd0);
        chk("async_accepted", 32'(move_accepted), 32'd0);
        chk("async_turn", 32'(player_turn), 32'd0);
        $display("async reset: board=%05h cnt=%0d acc=%0d", board_status, move_count, move_accepted);
        @(negedge clk);
        clr_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("held_enter_no_move", 32'({move_accepted, move_rejected}), 32'd0);
            chk("held_enter_board", 32'(board_status), 32'd0);
        end
        enter = 1'b0;
        @(negedge clk);
        enter = 1'b1;
        @(negedge clk);
        chk("repress_accepted", 32'(move_accepted), 32'd1);
        chk("repress_board", 32'(board_status), 32'(brd(9'b000010000, 9'b000000000)));
        $display("re-press: acc=%0d board=%05h", move_accepted, board_status);
        enter = 1'b0;
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
